// File: rtl/stack_bus_master.sv
// Bus initiator for a 5-entry stack responder. It turns valid/ready requests into
// COMMAND/INDEX/IO_DATA cycles, returns read data and tracks occupancy and errors.
module stack_bus_master #(
  parameter int DEPTH = 5
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic [1:0] REQ_CMD,
  input  logic [2:0] REQ_INDEX,
  input  logic [3:0] REQ_DATA,
  output logic       RSP_VALID,
  output logic [3:0] RSP_DATA,
  output logic [1:0] COMMAND,
  output logic [2:0] INDEX,
  inout  wire  [3:0] IO_DATA,
  output logic [2:0] COUNT,
  output logic       EMPTY,
  output logic       FULL,
  output logic       ERR,
  input  logic       ERR_CLR
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    TURN  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'b00,
    CMD_PUSH = 2'b01,
    CMD_POP  = 2'b10,
    CMD_GET  = 2'b11
  } cmd_e;

  localparam logic [2:0] DepthC = 3'(DEPTH);

  state_e     state_q, state_d;
  cmd_e       cmd_q, cmd_d;
  logic [2:0] index_q, index_d;
  logic [3:0] data_q, data_d;
  logic [3:0] rsp_data_q, rsp_data_d;
  logic [2:0] count_q, count_d;
  logic       err_q, err_d;
  logic       new_err;
  logic       idle_ready;
  logic       io_drive;

  // NOTE: every combinational output gets a default before the case so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    index_d    = index_q;
    data_d     = data_q;
    rsp_data_d = rsp_data_q;
    count_d    = count_q;
    new_err    = 1'b0;
    idle_ready = 1'b0;
    io_drive   = 1'b0;
    COMMAND    = CMD_NOP;
    RSP_VALID  = 1'b0;

    case (state_q)
      IDLE: begin
        idle_ready = 1'b1;
        if (REQ_VALID && (REQ_CMD != CMD_NOP)) begin
          state_d = ISSUE;
          cmd_d   = cmd_e'(REQ_CMD);
          index_d = REQ_INDEX;
          data_d  = REQ_DATA;
        end
      end

      ISSUE: begin
        COMMAND = cmd_q;
        case (cmd_q)
          CMD_PUSH: begin
            io_drive = 1'b1;
            state_d  = IDLE;
            if (count_q == DepthC) new_err = 1'b1;
            else                   count_d = count_q + 3'd1;
          end
          CMD_POP: begin
            state_d    = TURN;
            rsp_data_d = IO_DATA;
            if (count_q == 3'd0) new_err = 1'b1;
            else                 count_d = count_q - 3'd1;
          end
          CMD_GET: begin
            state_d    = TURN;
            rsp_data_d = IO_DATA;
            if (index_q >= count_q) new_err = 1'b1;
          end
          default: state_d = IDLE;
        endcase
      end

      TURN: begin
        RSP_VALID = 1'b1;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // A fresh error outranks a simultaneous clear.
    err_d = new_err | (err_q & ~ERR_CLR);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDLE;
      cmd_q      <= CMD_NOP;
      index_q    <= 3'd0;
      data_q     <= 4'd0;
      rsp_data_q <= 4'd0;
      count_q    <= 3'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      index_q    <= index_d;
      data_q     <= data_d;
      rsp_data_q <= rsp_data_d;
      count_q    <= count_d;
      err_q      <= err_d;
    end
  end

  // Ready is gated by reset itself so it reads 0 while reset is held, not just after.
  assign REQ_READY = idle_ready & RESET;
  assign IO_DATA   = io_drive ? data_q : 4'bzzzz;
  assign INDEX     = index_q;
  assign RSP_DATA  = rsp_data_q;
  assign COUNT     = count_q;
  assign EMPTY     = (count_q == 3'd0);
  assign FULL      = (count_q == DepthC);
  assign ERR       = err_q;

endmodule

// File: tb/tb_stack_bus_master.sv
// Self-checking bench: behavioural stack responder on the shared bus plus a queue-based
// reference model of the stack contents, occupancy and sticky error.
module tb_stack_bus_master;

  localparam int DEPTH = 5;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       REQ_VALID = 1'b0;
  logic       REQ_READY;
  logic [1:0] REQ_CMD = 2'b00;
  logic [2:0] REQ_INDEX = 3'd0;
  logic [3:0] REQ_DATA = 4'd0;
  logic       RSP_VALID;
  logic [3:0] RSP_DATA;
  logic [1:0] COMMAND;
  logic [2:0] INDEX;
  wire  [3:0] IO_DATA;
  logic [2:0] COUNT;
  logic       EMPTY;
  logic       FULL;
  logic       ERR;
  logic       ERR_CLR = 1'b0;

  stack_bus_master #(.DEPTH(DEPTH)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_CMD   (REQ_CMD),
    .REQ_INDEX (REQ_INDEX),
    .REQ_DATA  (REQ_DATA),
    .RSP_VALID (RSP_VALID),
    .RSP_DATA  (RSP_DATA),
    .COMMAND   (COMMAND),
    .INDEX     (INDEX),
    .IO_DATA   (IO_DATA),
    .COUNT     (COUNT),
    .EMPTY     (EMPTY),
    .FULL      (FULL),
    .ERR       (ERR),
    .ERR_CLR   (ERR_CLR)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Stack responder: drives IO_DATA combinationally while it sees POP or GET.
  logic [3:0] mem [DEPTH];
  int         resp_n;
  int         sel;
  logic [3:0] resp_val;
  logic       resp_drive;

  always_comb begin
    resp_drive = (COMMAND == 2'b10) || (COMMAND == 2'b11);
    sel        = (COMMAND == 2'b10) ? 0 : int'(INDEX);
    resp_val   = 4'h0;
    if (sel < resp_n) resp_val = mem[sel];
  end

  assign IO_DATA = resp_drive ? resp_val : 4'bzzzz;

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      resp_n <= 0;
    end else if (COMMAND == 2'b01) begin
      for (int i = DEPTH - 1; i > 0; i--) mem[i] <= mem[i-1];
      mem[0] <= IO_DATA;
      if (resp_n < DEPTH) resp_n <= resp_n + 1;
    end else if (COMMAND == 2'b10) begin
      for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
      if (resp_n > 0) resp_n <= resp_n - 1;
    end
  end

  // Reference model: element 0 is the top of stack.
  logic [3:0] ref_q[$];
  logic       ref_err = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int last_acc = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_count"}, 8'(COUNT), 8'(ref_q.size()));
    check({tag, "_err"},   8'(ERR),   8'(ref_err));
    check({tag, "_empty"}, 8'(EMPTY), 8'(ref_q.size() == 0));
    check({tag, "_full"},  8'(FULL),  8'(ref_q.size() == DEPTH));
  endtask

  // Called at a falling edge with the DUT idle; returns at a falling edge with it idle again.
  task automatic do_req(input logic [1:0] cmd, input logic [2:0] idx, input logic [3:0] data,
                        input logic clr);
    logic [3:0] exp_d;
    logic       nerr;
    int         n;
    exp_d = 4'h0;
    nerr  = 1'b0;
    check("ready_idle", 8'(REQ_READY), 8'd1);
    REQ_VALID = 1'b1;
    REQ_CMD   = cmd;
    REQ_INDEX = idx;
    REQ_DATA  = data;
    @(posedge CLK);
    @(negedge CLK);
    last_acc = cyc;
    if (cmd == 2'b00) begin
      check("nop_ready",   8'(REQ_READY), 8'd1);
      check("nop_command", 8'(COMMAND),   8'd0);
      check("nop_rsp",     8'(RSP_VALID), 8'd0);
      REQ_VALID = 1'b0;
      @(negedge CLK);
      check("nop_rsp2",    8'(RSP_VALID), 8'd0);
      check_state("nop");
      return;
    end
    n = ref_q.size();
    case (cmd)
      2'b01: begin
        nerr = (n == DEPTH);
        if (nerr) void'(ref_q.pop_back());
        ref_q.push_front(data);
      end
      2'b10: begin
        nerr = (n == 0);
        if (!nerr) exp_d = ref_q.pop_front();
      end
      default: begin
        nerr = (int'(idx) >= n);
        if (!nerr) exp_d = ref_q[idx];
      end
    endcase
    ref_err = nerr | (ref_err & ~clr);

    check("issue_command", 8'(COMMAND),   8'(cmd));
    check("issue_index",   8'(INDEX),     8'(idx));
    check("issue_ready",   8'(REQ_READY), 8'd0);
    check("issue_rsp",     8'(RSP_VALID), 8'd0);
    if (cmd == 2'b01) check("issue_push_bus", 8'(IO_DATA), 8'(data));
    else              check("issue_read_bus", 8'(IO_DATA), 8'(exp_d));
    // Scramble the request inputs: they must be ignored once accepted.
    REQ_VALID = 1'b0;
    REQ_CMD   = 2'($urandom);
    REQ_INDEX = 3'($urandom);
    REQ_DATA  = 4'($urandom);
    ERR_CLR   = clr;
    @(negedge CLK);
    ERR_CLR = 1'b0;
    if (cmd == 2'b01) begin
      check("push_after_ready", 8'(REQ_READY), 8'd1);
      check("push_after_cmd",   8'(COMMAND),   8'd0);
      check("push_after_rsp",   8'(RSP_VALID), 8'd0);
      check_state("push");
    end else begin
      check("turn_rsp_valid", 8'(RSP_VALID), 8'd1);
      check("turn_rsp_data",  8'(RSP_DATA),  8'(exp_d));
      check("turn_command",   8'(COMMAND),   8'd0);
      check("turn_ready",     8'(REQ_READY), 8'd0);
      check("turn_index",     8'(INDEX),     8'(idx));
      check_state("read");
      @(negedge CLK);
      check("read_after_rsp",   8'(RSP_VALID), 8'd0);
      check("read_after_ready", 8'(REQ_READY), 8'd1);
      check("read_hold_data",   8'(RSP_DATA),  8'(exp_d));
    end
  endtask

  task automatic clear_err();
    ERR_CLR = 1'b1;
    @(negedge CLK);
    ERR_CLR = 1'b0;
    ref_err = 1'b0;
    check("err_clr", 8'(ERR), 8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pop_acc;
    int gap;
    logic [1:0] rc;
    logic       rclr;

    // Reset values while RESET is held low.
    #2;
    check("rst_ready",    8'(REQ_READY), 8'd0);
    check("rst_command",  8'(COMMAND),   8'd0);
    check("rst_index",    8'(INDEX),     8'd0);
    check("rst_rsp",      8'(RSP_VALID), 8'd0);
    check("rst_rsp_data", 8'(RSP_DATA),  8'd0);
    check_state("rst");
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);

    // PUSH then POP.
    do_req(2'b01, 3'd0, 4'hA, 1'b0);
    do_req(2'b10, 3'd0, 4'h0, 1'b0);

    // GET by depth, then out-of-range GET and clear.
    do_req(2'b01, 3'd0, 4'h1, 1'b0);
    do_req(2'b01, 3'd0, 4'h2, 1'b0);
    do_req(2'b01, 3'd0, 4'h3, 1'b0);
    do_req(2'b11, 3'd2, 4'h0, 1'b0);
    do_req(2'b11, 3'd3, 4'h0, 1'b0);
    check("get_oob_err", 8'(ERR), 8'd1);
    clear_err();

    // Full and empty boundaries; the last PUSH overflows with a simultaneous clear.
    for (int i = 0; i < 3; i++) do_req(2'b10, 3'd0, 4'h0, 1'b0);
    for (int i = 0; i < 6; i++) do_req(2'b01, 3'd0, 4'(4'h4 + i), (i == 5));
    check("full_flag", 8'(FULL), 8'd1);
    check("full_err",  8'(ERR),  8'd1);
    clear_err();
    for (int i = 0; i < 6; i++) do_req(2'b10, 3'd0, 4'h0, 1'b0);
    check("empty_flag", 8'(EMPTY), 8'd1);
    check("empty_err",  8'(ERR),   8'd1);
    clear_err();

    // Bus ownership: POP immediately followed by PUSH.
    do_req(2'b01, 3'd0, 4'h5, 1'b0);
    do_req(2'b10, 3'd0, 4'h0, 1'b0);
    pop_acc = last_acc;
    do_req(2'b01, 3'd0, 4'h7, 1'b0);
    gap = last_acc - pop_acc;
    check("pop_push_gap", 8'(gap), 8'd3);

    // NOP request.
    do_req(2'b00, 3'd0, 4'h0, 1'b0);

    // Reset during a GET ISSUE cycle.
    REQ_VALID = 1'b1;
    REQ_CMD   = 2'b11;
    REQ_INDEX = 3'd0;
    @(posedge CLK);
    @(negedge CLK);
    REQ_VALID = 1'b0;
    check("rst_mid_issue", 8'(COMMAND), 8'h3);
    #1 RESET = 1'b0;
    #1;
    ref_q.delete();
    ref_err = 1'b0;
    check("rst_mid_command", 8'(COMMAND),   8'd0);
    check("rst_mid_index",   8'(INDEX),     8'd0);
    check("rst_mid_ready",   8'(REQ_READY), 8'd0);
    check("rst_mid_rsp",     8'(RSP_VALID), 8'd0);
    check("rst_mid_rspdata", 8'(RSP_DATA),  8'd0);
    check_state("rst_mid");
    @(negedge CLK);
    RESET = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("rst_no_rsp", 8'(RSP_VALID), 8'd0);
      check("rst_idle_cmd", 8'(COMMAND), 8'd0);
    end

    // Randomized traffic against the reference model.
    for (int i = 0; i < 120; i++) begin
      rc   = 2'($urandom_range(0, 3));
      rclr = (rc != 2'b00) && ($urandom_range(0, 7) == 0);
      do_req(rc, 3'($urandom_range(0, 7)), 4'($urandom), rclr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stack_bus_master.md
# stack_bus_master

Initiator for the 4-bit stack command bus: it accepts push, pop and peek requests on a valid/ready request port and drives `COMMAND`, `INDEX` and `IO_DATA` toward a 5-entry stack responder. On reads it releases `IO_DATA`, captures the value the stack drives back, and returns it on a one-cycle response strobe. It also tracks stack occupancy and raises a sticky error on pop-when-empty, peek-out-of-range and push-when-full.

## Interface
Parameters:
- `DEPTH`, 5: stack responder capacity. Sets the occupancy limit.

Ports:
- `CLK` in 1: single clock, shared with the stack responder.
- `RESET` in 1: asynchronous, active-low reset.
- `REQ_VALID` in 1: request present.
- `REQ_READY` out 1: request accepted when high with `REQ_VALID` at a rising edge.
- `REQ_CMD` in 2: 00 NOP, 01 PUSH, 10 POP, 11 GET.
- `REQ_INDEX` in 3: GET depth; 0 is the top of stack.
- `REQ_DATA` in 4: PUSH data.
- `RSP_VALID` out 1: one-cycle pulse when read data is available.
- `RSP_DATA` out 4: captured POP/GET data. Holds its value until the next read completes.
- `COMMAND` out 2: stack bus command.
- `INDEX` out 3: stack bus index.
- `IO_DATA` inout 4: shared data bus. The master drives it only during a PUSH issue cycle; otherwise it is 4'bZZZZ.
- `COUNT` out 3: stack occupancy, 0..DEPTH.
- `EMPTY` out 1: `COUNT == 0`.
- `FULL` out 1: `COUNT == DEPTH`.
- `ERR` out 1: sticky protocol error flag.
- `ERR_CLR` in 1: synchronous clear for `ERR`.

## Operation
FSM with states IDLE, ISSUE and TURN.

- **IDLE**
  - Outputs: `REQ_READY=1`, `COMMAND=00`, `IO_DATA` Z.
  - An accepted PUSH, POP or GET registers cmd, index and data, then goes to ISSUE.
  - An accepted NOP is consumed and the FSM stays in IDLE.
- **ISSUE** (exactly 1 cycle)
  - Outputs: `REQ_READY=0`, `COMMAND`/`INDEX` = the registered values.
  - `IO_DATA` = registered data for PUSH; Z for POP and GET.
  - Next state: PUSH goes to IDLE; POP and GET go to TURN.
  - POP/GET only: `IO_DATA` is sampled into `RSP_DATA` at the rising edge that ends ISSUE.
- **TURN** (exactly 1 cycle)
  - Outputs: `COMMAND=00`, `IO_DATA` Z, `REQ_READY=0`, `RSP_VALID=1`.
  - Purpose: the bus turnaround lets the responder release `IO_DATA` (it sees NOP) before any later PUSH drives it.
  - Next state: IDLE.
- **INDEX** outside ISSUE holds its last value; it is 0 after reset.
- **Occupancy** updates at the edge that ends ISSUE:
  - PUSH: `COUNT` += 1, saturating at DEPTH. PUSH when FULL sets `ERR`; the responder overwrites its oldest entry.
  - POP: `COUNT` -= 1, saturating at 0. POP when EMPTY sets `ERR`.
  - GET: `COUNT` unchanged. GET with `INDEX >= COUNT` sets `ERR`.
- **Errored requests** are still issued on the bus and still produce a response. The master only flags them; it never blocks them.
- **`ERR` clearing:** `ERR_CLR` clears `ERR` at the next edge. A simultaneous new error wins, so `ERR` stays 1.
- **Reset values:** `RESET` low forces, asynchronously:
  - state IDLE, `REQ_READY=0` (1 after release), `COMMAND=00`, `INDEX=0`, `IO_DATA` Z;
  - `RSP_VALID=0`, `RSP_DATA=0`, `COUNT=0`, `ERR=0`.
- **Reset mid-operation:** aborts ISSUE or TURN, releases the bus immediately, and emits no response.
- **Reset connection:** the responder's reset is tied to the same net, so `COUNT=0` matches an empty stack.

## Timing
- **PUSH:** accepted at edge k; `COMMAND=01` with data on `IO_DATA` during cycle k..k+1; `REQ_READY` high again from k+1. Throughput is 1 PUSH per 2 cycles.
- **POP/GET:** accepted at edge k; command driven during k..k+1; `RSP_DATA` captured at k+1; `RSP_VALID` high during k+1..k+2; ready again from k+2. Latency from accept to `RSP_VALID` is 1 cycle; throughput is 1 read per 3 cycles.
- **Bus ownership:** the master never drives `IO_DATA` in the cycle following a POP/GET issue.
- **Request stability:** `REQ_*` are sampled only at the accepting edge; later changes are ignored.

## Test plan
- **PUSH then POP:** reset, PUSH 4'hA. Expect `COMMAND=01` and `IO_DATA=A` for one cycle, `COUNT=1`. Then POP with the stack model returning A: `RSP_VALID` pulses one cycle after accept, `RSP_DATA=A`, `COUNT=0`, `ERR=0`.
- **GET by depth:** PUSH 1,2,3, then GET `INDEX=2`. Expect `INDEX=2` on the bus, `RSP_DATA=1`, `COUNT=3`. GET `INDEX=3` also completes but sets `ERR=1`; `ERR_CLR` returns it to 0.
- **Full and empty boundaries:** 6 PUSHes leave `COUNT=5`, `FULL=1`, `ERR=1`. 6 POPs leave `COUNT=0`, `EMPTY=1`, with the 6th POP setting `ERR`.
- **Bus ownership:** POP immediately followed by PUSH. Check `IO_DATA` is Z during ISSUE and TURN of the POP, PUSH issue starts no earlier than 3 cycles after the POP accept, and no X contention appears.
- **Reset during ISSUE:** assert `RESET` low during a GET ISSUE cycle. Outputs go to reset values within the same cycle, `IO_DATA` goes Z, and no `RSP_VALID` appears after release.
- **NOP request:** accepted in IDLE with `REQ_READY` staying 1, `COMMAND` staying 00, and no `RSP_VALID`.
